// File: rtl/etc1_pkg.sv
// Shared constants and types for the ETC1 individual-mode encoder.
package etc1_pkg;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_BASE,
        ST_SCAN,
        ST_INDEX,
        ST_DONE
    } state_e;

    localparam logic [7:0] MOD_SMALL [8] = '{8'd2, 8'd5, 8'd9, 8'd13, 8'd18, 8'd24, 8'd33, 8'd47};
    localparam logic [7:0] MOD_LARGE [8] = '{8'd8, 8'd17, 8'd29, 8'd42, 8'd60, 8'd80, 8'd106, 8'd183};

    // d3 sums three channels, so both thresholds carry a factor of 3.
    localparam logic [10:0] THR_LARGE3 [8] = '{
        11'(3 * MOD_LARGE[0]), 11'(3 * MOD_LARGE[1]), 11'(3 * MOD_LARGE[2]), 11'(3 * MOD_LARGE[3]),
        11'(3 * MOD_LARGE[4]), 11'(3 * MOD_LARGE[5]), 11'(3 * MOD_LARGE[6]), 11'(3 * MOD_LARGE[7])};
    localparam logic [10:0] THR_SPLIT3 [8] = '{
        11'(3 * (MOD_SMALL[0] + MOD_LARGE[0])), 11'(3 * (MOD_SMALL[1] + MOD_LARGE[1])),
        11'(3 * (MOD_SMALL[2] + MOD_LARGE[2])), 11'(3 * (MOD_SMALL[3] + MOD_LARGE[3])),
        11'(3 * (MOD_SMALL[4] + MOD_LARGE[4])), 11'(3 * (MOD_SMALL[5] + MOD_LARGE[5])),
        11'(3 * (MOD_SMALL[6] + MOD_LARGE[6])), 11'(3 * (MOD_SMALL[7] + MOD_LARGE[7]))};

    localparam int R1_LSB   = 60;
    localparam int R2_LSB   = 56;
    localparam int G1_LSB   = 52;
    localparam int G2_LSB   = 48;
    localparam int B1_LSB   = 44;
    localparam int B2_LSB   = 40;
    localparam int T1_LSB   = 37;
    localparam int T2_LSB   = 34;
    localparam int DIFF_BIT = 33;
    localparam int FLIP_BIT = 32;

endpackage

// File: rtl/etc1_index_select.sv
// Picks the 2-bit ETC1 index for one d3 under table t; fits_o flags that t can reach |d3|.
module etc1_index_select
    import etc1_pkg::*;
(
    input  logic signed [10:0] d3_i,
    input  logic [2:0]         t_i,
    output logic [1:0]         idx_o,
    output logic               fits_o
);

    logic [10:0] mag;
    logic [11:0] mag2;

    always_comb begin
        mag    = d3_i[10] ? 11'(-d3_i) : 11'(d3_i);
        mag2   = {mag, 1'b0};
        idx_o  = {d3_i[10], (mag2 >= {1'b0, THR_SPLIT3[t_i]})};
        fits_o = (THR_LARGE3[t_i] >= mag);
    end

endmodule

// File: rtl/etc1_encode.sv
// Streaming 4x4 RGB888 -> ETC1 block encoder, individual mode with vertical split.
module etc1_encode
    import etc1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block
);

    function automatic logic [3:0] quant4(input logic [10:0] sum);
        logic [11:0] prod;
        prod = 12'(sum[10:3]) * 12'd15 + 12'd128;
        return prod[11:8];
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] pix_q [16];
    logic [10:0] sum_q [2][3];
    logic [3:0]  base_q [2][3];
    logic [10:0] max_q [2];
    logic [2:0]  tbl_q [2];
    logic [31:0] idx_q;
    logic        out_vld_q;
    logic [63:0] out_blk_q;

    logic               accept;
    logic               in_sb, cur_sb;
    logic [23:0]        cur_pix;
    logic signed [10:0] d3;
    logic [10:0]        mag;
    logic [15:0]        fit;
    logic [1:0]         search_idx_unused [16];
    logic [2:0]         t_found [2];
    logic [2:0]         tbl_use;
    logic [1:0]         idx_cur;
    logic               fits_cur_unused;
    logic [63:0]        blk_d;

    assign in_ready  = (state_q == ST_COLLECT);
    assign out_valid = out_vld_q;
    assign out_block = out_blk_q;
    assign accept    = in_valid && in_ready;
    assign in_sb     = cnt_q[1];
    assign cur_sb    = cnt_q[3];
    // Counter runs in p = 4x+y order; the buffer is stored in raster beat order.
    assign cur_pix   = pix_q[{cnt_q[1:0], cnt_q[3:2]}];

    always_comb begin
        d3 = '0;
        for (int c = 0; c < 3; c++) begin
            d3 = d3 + $signed({3'b0, cur_pix[23-8*c -: 8]})
                    - $signed({3'b0, base_q[cur_sb][c], base_q[cur_sb][c]});
        end
        mag = d3[10] ? 11'(-d3) : 11'(d3);
    end

    for (genvar s = 0; s < 2; s++) begin : g_sb
        for (genvar t = 0; t < 8; t++) begin : g_tbl
            etc1_index_select u_fit (
                .d3_i   ($signed(max_q[s])),
                .t_i    (3'(t)),
                .idx_o  (search_idx_unused[s*8+t]),
                .fits_o (fit[s*8+t])
            );
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            t_found[s] = 3'd7;
            for (int t = 7; t >= 0; t--) begin
                if (fit[s*8+t]) t_found[s] = 3'(t);
            end
        end
        // Table is latched on the first INDEX cycle, so pixel 0 takes it straight from the search.
        tbl_use = (cnt_q == 4'd0) ? t_found[cur_sb] : tbl_q[cur_sb];
    end

    etc1_index_select u_idx (
        .d3_i   (d3),
        .t_i    (tbl_use),
        .idx_o  (idx_cur),
        .fits_o (fits_cur_unused)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_COLLECT: if (accept) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = ST_BASE;
            end
            ST_BASE: begin
                cnt_d   = 4'd0;
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = ST_INDEX;
            end
            ST_INDEX: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = ST_DONE;
            end
            ST_DONE: if (out_vld_q && out_ready) state_d = ST_COLLECT;
            default: state_d = ST_COLLECT;
        endcase
    end

    always_comb begin
        blk_d                 = '0;
        blk_d[R1_LSB +: 4]    = base_q[0][0];
        blk_d[R2_LSB +: 4]    = base_q[1][0];
        blk_d[G1_LSB +: 4]    = base_q[0][1];
        blk_d[G2_LSB +: 4]    = base_q[1][1];
        blk_d[B1_LSB +: 4]    = base_q[0][2];
        blk_d[B2_LSB +: 4]    = base_q[1][2];
        blk_d[T1_LSB +: 3]    = tbl_q[0];
        blk_d[T2_LSB +: 3]    = tbl_q[1];
        blk_d[DIFF_BIT]       = 1'b0;
        blk_d[FLIP_BIT]       = 1'b0;
        blk_d[31:0]           = idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            out_blk_q <= '0;
            for (int s = 0; s < 2; s++) begin
                max_q[s] <= '0;
                for (int c = 0; c < 3; c++) sum_q[s][c] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_COLLECT && accept) begin
                for (int c = 0; c < 3; c++)
                    sum_q[in_sb][c] <= sum_q[in_sb][c] + 11'(in_pixel[23-8*c -: 8]);
            end
            if (state_q == ST_BASE) begin
                for (int s = 0; s < 2; s++) begin
                    max_q[s] <= '0;
                    for (int c = 0; c < 3; c++) sum_q[s][c] <= '0;
                end
            end
            if (state_q == ST_SCAN && mag > max_q[cur_sb]) max_q[cur_sb] <= mag;
            if (state_q == ST_DONE && !out_vld_q) begin
                out_vld_q <= 1'b1;
                out_blk_q <= blk_d;
            end else if (out_vld_q && out_ready) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_COLLECT && accept) pix_q[cnt_q] <= in_pixel;
        if (state_q == ST_BASE) begin
            for (int s = 0; s < 2; s++)
                for (int c = 0; c < 3; c++) base_q[s][c] <= quant4(sum_q[s][c]);
        end
        if (state_q == ST_INDEX) begin
            if (cnt_q == 4'd0) begin
                tbl_q[0] <= t_found[0];
                tbl_q[1] <= t_found[1];
            end
            idx_q[{1'b1, cnt_q}] <= idx_cur[1];
            idx_q[{1'b0, cnt_q}] <= idx_cur[0];
        end
    end

endmodule
